// File: rtl/mux8_pkg.sv
// ---------------------------------------------------------------------------
// mux8_pkg - shared constants, select type and pointer helper for rr_mux_8to1
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mux8_pkg;

  localparam int NCH   = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;

  // Successor of a channel index; the 3-bit width makes 7 wrap to 0.
  function automatic sel_t next_ptr(input sel_t cur);
    return sel_t'(cur + sel_t'(1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter8.sv
// ---------------------------------------------------------------------------
// rr_arbiter8 - combinational rotate-priority search over 8 requests from ptr
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter8
  import mux8_pkg::*;
(
  input  logic [NCH-1:0] req,
  input  logic [2:0]     ptr,
  output logic [NCH-1:0] gnt_onehot,
  output logic [2:0]     gnt_idx,
  output logic           gnt_any
);

  sel_t idx;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_any    = 1'b0;
    idx        = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = sel_t'(ptr + sel_t'(k));
      if (!gnt_any && req[idx]) begin
        gnt_any         = 1'b1;
        gnt_idx         = idx;
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_mux_8to1.sv
// ---------------------------------------------------------------------------
// rr_mux_8to1 - 8-to-1 round-robin stream collector with registered output;
// define MUX8_PKT_LOCK_EN to hold the grant until in_last.   rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_mux_8to1
  import mux8_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        in_valid,
  input  logic [NCH*DATA_W-1:0] in_data,
  output logic [NCH-1:0]        in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [2:0]            out_sel,
  input  logic [NCH-1:0]        in_last
);

  sel_t              ptr;
  logic              load;
  logic              take;
  logic              ptr_adv;
  logic [NCH-1:0]    req;
  logic [NCH-1:0]    gnt_onehot;
  logic [2:0]        gnt_idx;
  logic              gnt_any;
  logic [DATA_W-1:0] win_data;

  // The output register can accept a word when empty or drained this cycle.
  assign load     = !out_valid || out_ready;
  assign take     = rst_n && load && gnt_any;
  assign in_ready = take ? gnt_onehot : '0;
  assign win_data = in_data[int'(gnt_idx)*DATA_W +: DATA_W];

`ifdef MUX8_PKT_LOCK_EN
  logic locked;
  sel_t lock_ch;

  // While a packet is open only its channel may request, idle or not.
  always_comb begin
    req = in_valid;
    if (locked) begin
      req          = '0;
      req[lock_ch] = in_valid[lock_ch];
    end
  end

  assign ptr_adv = in_last[gnt_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      locked  <= 1'b0;
      lock_ch <= '0;
    end else if (take) begin
      locked  <= !in_last[gnt_idx];
      lock_ch <= gnt_idx;
    end
  end
`else
  logic unused_last;

  assign req         = in_valid;
  assign ptr_adv     = 1'b1;
  assign unused_last = ^in_last;
`endif

  rr_arbiter8 u_arb (
    .req        (req),
    .ptr        (ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .gnt_any    (gnt_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (take && ptr_adv) begin
      ptr <= next_ptr(gnt_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load) begin
      if (gnt_any) begin
        out_valid <= 1'b1;
        out_data  <= win_data;
        out_sel   <= gnt_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
